// File: rtl/l2_probe_ctrl.sv
// l2_probe_ctrl: TileLink-C probe engine for the coherent L2. It probes the
// selected masters on channel B, collects their ProbeAck/ProbeAckData
// responses on channel C, streams dirty beats to the L2 writeback path and
// reports the residual copies, dirty flag and corrupt flag on completion.
//
// Ports:
//   l2_clock_i, l2_reset_i      clock, synchronous active-high reset
//   req_*                       probe request from the L2 coherence FSM
//   b_*                         channel B probe issue, one valid per master
//   c_*                         channel C responses, one lane per master
//   wb_*                        dirty beat stream, no backpressure
//   done_*                      one-cycle completion report
//
// Optional feature: define PROBE_TIMEOUT_EN to add a watchdog that
// abandons a probe after TIMEOUT_CYCLES cycles without any B/C handshake.
// Without it done_timeout is tied low and ACTIVE waits indefinitely.

module l2_probe_ctrl #(
  parameter int TL_AW          = 29,
  parameter int NUM_MASTERS    = 2,
  parameter int LINE_BEATS     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       l2_clock_i,
  input  logic                       l2_reset_i,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [TL_AW-1:0]           req_address,
  input  logic [1:0]                 req_cap,
  input  logic [NUM_MASTERS-1:0]     req_mask,
  output logic [NUM_MASTERS-1:0]     b_valid,
  input  logic [NUM_MASTERS-1:0]     b_ready,
  output logic [2:0]                 b_opcode,
  output logic [2:0]                 b_param,
  output logic [3:0]                 b_size,
  output logic [TL_AW-1:0]           b_address,
  output logic [15:0]                b_mask,
  input  logic [NUM_MASTERS-1:0]     c_valid,
  output logic [NUM_MASTERS-1:0]     c_ready,
  input  logic [3*NUM_MASTERS-1:0]   c_opcode,
  input  logic [3*NUM_MASTERS-1:0]   c_param,
  input  logic [128*NUM_MASTERS-1:0] c_data,
  input  logic [NUM_MASTERS-1:0]     c_corrupt,
  output logic                       wb_valid,
  output logic [TL_AW-1:0]           wb_address,
  output logic [127:0]               wb_data,
  output logic                       done_valid,
  output logic                       done_dirty,
  output logic                       done_corrupt,
  output logic [NUM_MASTERS-1:0]     done_has_copy,
  output logic                       done_timeout
);

  localparam int BW  = $clog2(LINE_BEATS);
  localparam int OFF = BW + 4;
  localparam int IW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [TL_AW-1:0] LOW =
    TL_AW'((64'd1 << OFF) - 64'd1);

  localparam logic [2:0] OP_ACK  = 3'd4;
  localparam logic [2:0] OP_DATA = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [TL_AW-1:0]       addr_q;
  logic [1:0]             cap_q;
  logic [NUM_MASTERS-1:0] pend_b_q;
  logic [NUM_MASTERS-1:0] pend_b_d;
  logic [NUM_MASTERS-1:0] pend_ack_q;
  logic [NUM_MASTERS-1:0] pend_ack_d;
  logic [NUM_MASTERS-1:0] copy_q;
  logic [NUM_MASTERS-1:0] copy_d;
  logic                   dirty_q;
  logic                   dirty_d;
  logic                   corrupt_q;
  logic                   corrupt_d;
  logic                   lock_q;
  logic                   lock_d;
  logic [IW-1:0]          gnt_q;
  logic [IW-1:0]          gnt_d;
  logic [IW-1:0]          rr_q;
  logic [IW-1:0]          rr_d;
  logic [BW-1:0]          beat_q;
  logic [BW-1:0]          beat_d;
  logic                   tmo_q;
  logic                   tmo_d;

  logic                   accept;
  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] b_fire;
  logic [IW-1:0]          win;
  logic                   win_ok;
  logic [IW-1:0]          sel;
  logic                   c_fire;
  logic [2:0]             sel_op;
  logic [2:0]             sel_par;
  logic                   is_data;
  logic                   last;
  logic                   keeps;
  logic                   tmo_fire;

  assign accept = (state_q == IDLE) && req_valid;

  assign b_fire = (state_q == ACTIVE) ?
                  (pend_b_q & b_ready) : '0;

  // A master may only answer once its probe has been handed over.
  assign elig = (state_q == ACTIVE) ?
                (pend_ack_q & ~pend_b_q & c_valid) : '0;

  // Round-robin search starting at rr_q.
  always_comb begin
    int j;
    j      = 0;
    win    = '0;
    win_ok = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (!win_ok && elig[j]) begin
        win    = IW'(j);
        win_ok = 1'b1;
      end
    end
  end

  // A ProbeAckData burst keeps the channel until its last beat.
  assign sel     = lock_q ? gnt_q : win;
  assign c_fire  = lock_q ? elig[gnt_q] : win_ok;
  assign sel_op  = c_opcode[3*int'(sel) +: 3];
  assign sel_par = c_param[3*int'(sel) +: 3];
  assign is_data = lock_q || (sel_op == OP_DATA);
  assign last    = !is_data ||
                   (beat_q == BW'(LINE_BEATS - 1));

  // TtoB, TtoT and BtoB leave a copy behind.
  assign keeps = (sel_par == 3'd0) ||
                 (sel_par == 3'd3) ||
                 (sel_par == 3'd4);

`ifdef PROBE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_q;
  logic          any_hs;

  assign any_hs = (|b_fire) || c_fire;

  // Fires on the idle cycle that would take the count to TIMEOUT_CYCLES.
  assign tmo_fire = (state_q == ACTIVE) && !any_hs &&
                    (wd_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge l2_clock_i) begin
    if (l2_reset_i) begin
      wd_q <= '0;
    end else if (accept || any_hs || state_q != ACTIVE) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    pend_b_d   = pend_b_q;
    pend_ack_d = pend_ack_q;
    copy_d     = copy_q;
    dirty_d    = dirty_q;
    corrupt_d  = corrupt_q;
    lock_d     = lock_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    beat_d     = beat_q;
    tmo_d      = tmo_q;
    if (accept) begin
      pend_b_d   = req_mask;
      pend_ack_d = req_mask;
      copy_d     = '0;
      dirty_d    = 1'b0;
      corrupt_d  = 1'b0;
      lock_d     = 1'b0;
      beat_d     = '0;
      tmo_d      = 1'b0;
    end else if (state_q == ACTIVE) begin
      pend_b_d = pend_b_q & ~b_fire;
      if (c_fire) begin
        corrupt_d = corrupt_q | c_corrupt[sel];
        if (is_data) dirty_d = 1'b1;
        if (!lock_q) begin
          copy_d[sel] = keeps;
          rr_d = (sel == IW'(NUM_MASTERS - 1)) ?
                 '0 : sel + 1'b1;
        end
        if (last) begin
          pend_ack_d[sel] = 1'b0;
          lock_d          = 1'b0;
          beat_d          = '0;
        end else begin
          lock_d = 1'b1;
          gnt_d  = sel;
          beat_d = beat_q + 1'b1;
        end
      end
      if (tmo_fire) begin
        pend_b_d   = '0;
        pend_ack_d = '0;
        lock_d     = 1'b0;
        beat_d     = '0;
        tmo_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge l2_clock_i) begin
    if (l2_reset_i) begin
      addr_q     <= '0;
      cap_q      <= '0;
      pend_b_q   <= '0;
      pend_ack_q <= '0;
      copy_q     <= '0;
      dirty_q    <= 1'b0;
      corrupt_q  <= 1'b0;
      lock_q     <= 1'b0;
      gnt_q      <= '0;
      rr_q       <= '0;
      beat_q     <= '0;
      tmo_q      <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= req_address & ~LOW;
        cap_q  <= req_cap;
      end
      pend_b_q   <= pend_b_d;
      pend_ack_q <= pend_ack_d;
      copy_q     <= copy_d;
      dirty_q    <= dirty_d;
      corrupt_q  <= corrupt_d;
      lock_q     <= lock_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      beat_q     <= beat_d;
      tmo_q      <= tmo_d;
    end
  end

  always_ff @(posedge l2_clock_i) begin
    if (l2_reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (req_mask == '0) ? DONE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (pend_ack_d == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready     = (state_q == IDLE);
    b_valid       = (state_q == ACTIVE) ? pend_b_q : '0;
    b_opcode      = 3'd6;
    b_param       = {1'b0, cap_q};
    b_size        = 4'(OFF);
    b_address     = addr_q;
    b_mask        = 16'hFFFF;
    c_ready       = '0;
    if (c_fire) c_ready[sel] = 1'b1;
    wb_valid      = c_fire && is_data;
    wb_address    = addr_q | (TL_AW'(beat_q) << 4);
    wb_data       = c_data[128*int'(sel) +: 128];
    done_valid    = (state_q == DONE);
    done_dirty    = done_valid && dirty_q;
    done_corrupt  = done_valid && corrupt_q;
    done_has_copy = done_valid ? copy_q : '0;
    done_timeout  = done_valid && tmo_q;
  end

endmodule

// File: doc/l2_probe_ctrl.md
Name: l2_probe_ctrl

Overview:
- Parametrised TileLink-C probe engine for the coherent L2 interconnect. It is the successor to the single-master coherence stub and generalises to NUM_MASTERS coherent masters.
- On a request from the L2 coherence FSM it probes every selected master on channel B and collects ProbeAck/ProbeAckData on channel C. It streams dirty line data to the L2 data-array writeback path.
- When all responses are in, it reports per-master residual copies, the dirty flag and the corrupt flag.

Parameters:
- TL_AW, 29, address width.
- NUM_MASTERS, 2, number of coherent masters (1..8).
- LINE_BEATS, 8, 128-bit beats per cache line (power of 2, 2..16).
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with PROBE_TIMEOUT_EN).

Ports:
- l2_clock_i  in  1  sole clock.
- l2_reset_i  in  1  synchronous active-high reset.
- req_valid  in  1  probe request.
- req_ready  out  1  high only in IDLE.
- req_address  in  TL_AW  line address; low log2(LINE_BEATS*16) bits ignored.
- req_cap  in  2  cap param: 0 toT, 1 toB, 2 toN.
- req_mask  in  NUM_MASTERS  masters to probe.
- b_valid  out  NUM_MASTERS  per-master B valid.
- b_ready  in  NUM_MASTERS  per-master B ready.
- b_opcode  out  3  constant 6 (ProbeBlock).
- b_param  out  3  latched cap.
- b_size  out  4  4+log2(LINE_BEATS).
- b_address  out  TL_AW  latched line address, low bits zero.
- b_mask  out  16  all ones.
- c_valid  in  NUM_MASTERS  per-master C valid.
- c_ready  out  NUM_MASTERS  per-master C ready.
- c_opcode  in  3*NUM_MASTERS  4 ProbeAck, 5 ProbeAckData.
- c_param  in  3*NUM_MASTERS  shrink/report param.
- c_data  in  128*NUM_MASTERS  beat data.
- c_corrupt  in  NUM_MASTERS  beat corrupt.
- wb_valid  out  1  dirty beat valid; no backpressure.
- wb_address  out  TL_AW  line address plus beat*16.
- wb_data  out  128  beat data.
- done_valid  out  1  one-cycle completion pulse.
- done_dirty  out  1  at least one ProbeAckData received.
- done_corrupt  out  1  any beat had corrupt set.
- done_has_copy  out  NUM_MASTERS  masters still holding a copy after the probe.
- done_timeout  out  1  watchdog fired (0 without the macro).

Behaviour:
- States: IDLE, ACTIVE, DONE.
- Reset sets state IDLE and clears all internal registers. Next cycle: b_valid=0, c_ready=0, wb_valid=0, done_*=0, req_ready=1. Reset mid-burst abandons the transaction with no done pulse.
- IDLE:
  - req_valid&req_ready latches address, cap and mask.
  - pend_b=mask, pend_ack=mask, has_copy=0, dirty=0, corrupt=0.
  - Next state ACTIVE; if mask==0, next state DONE directly.
- ACTIVE, B side:
  - b_valid[i]=pend_b[i], first asserted the cycle after acceptance.
  - pend_b[i] clears on b_valid[i]&b_ready[i]. Masters handshake independently in any order.
- ACTIVE, C side:
  - Eligible master: pend_ack[i] & ~pend_b[i] & c_valid[i]. c_ready is never raised for an ineligible master.
  - One master is granted at a time, chosen round-robin; the pointer advances past the winner.
  - The grant locks until the response ends.
  - ProbeAck: single beat.
  - ProbeAckData: LINE_BEATS beats counted by a log2(LINE_BEATS)-bit beat counter that wraps to 0. Each beat drives wb_valid the same cycle with data and address; dirty is set.
  - On the last beat, pend_ack[i] clears, the lock releases and the counter resets.
  - Opcode 4 or 5 is latched from the first beat.
  - has_copy[i] is set when param is TtoB(0), TtoT(3) or BtoB(4). It is clear for TtoN(1), BtoN(2) and NtoN(5).
  - corrupt |= c_corrupt on every beat.
- Simultaneous B handshake and C beat of different masters are both serviced in one cycle.
- ACTIVE -> DONE in the cycle after pend_ack becomes 0.
- DONE: done_valid=1 for exactly one cycle with the done_* values, then IDLE. Because req_ready=0 in DONE, the earliest next acceptance is one cycle after the pulse.
- Latency for one master with zero-wait ready: request (T0), B handshake T1, ProbeAck T2, done_valid T3.

Optional Feature:
- PROBE_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entering ACTIVE and on every B/C handshake, and increments otherwise.
  - At TIMEOUT_CYCLES it forces DONE with done_timeout=1, drops all b_valid/c_ready and clears pend_b/pend_ack. has_copy is left as collected.
- PROBE_TIMEOUT_EN undefined: no counter; done_timeout tied 0; ACTIVE waits indefinitely.

Test Plan:
- Reset mid-ProbeAckData (beat 3 of 8), then new request -> no done pulse; fresh transaction completes normally, beat counter restarts at 0.
- NUM_MASTERS=2, mask=2'b01, cap=toN, master0 ProbeAck param=TtoN(1) -> b_valid=01 at T1, done at T3, dirty=0, has_copy=00.
- mask=2'b11, cap=toB, both ProbeAckData param=TtoB(0) arriving the same cycle -> master0 granted first; 8 beats then 8 beats; 16 consecutive wb_valid; wb_address increments by 0x10 and wraps per line; done_dirty=1, has_copy=11.
- mask=0 -> no b_valid; done_valid one cycle after acceptance with all flags 0.
- b_ready[1] held low 20 cycles while master0 responds -> c_ready[1] stays 0 until the B handshake; done only after master1's ack.
- With PROBE_TIMEOUT_EN and TIMEOUT_CYCLES=16, master never responds -> done_valid at cycle 17 of ACTIVE with done_timeout=1; b_valid and c_ready deasserted.
